alu_exec_ctrl: RTL

- Sequencing front-end that drives the 32-bit shifter/ALU datapath and owns the architectural NZCV flag register.
- Accepts one conditional data-processing request through a valid/ready handshake.
- Evaluates the 4-bit condition code against the stored flags, registers the operands onto the ALU inputs, and captures F and the new NZCV.
- Returns the result through a response valid/ready handshake.
- Sits between the decode stage (upstream) and the register-file write port (downstream). The ALU datapath hangs off its alu_* ports.

---
 rtl/alu_exec_pkg.sv | 33 +++
 rtl/alu_exec_ctrl_cond_check.sv | 41 ++++
 rtl/alu_exec_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/alu_exec_pkg.sv
// Shared constants for the ALU execute controller: condition codes, NZCV bit
// positions and the controller FSM encoding.
package alu_exec_pkg;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_exec_ctrl_cond_check.sv
// Condition-code evaluator: purely combinational, zero latency, no handshake.
// Decides whether an instruction executes given cond and the current {N,Z,C,V}.
module cond_check
  import alu_exec_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_nzcv,
  output logic       o_pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_nzcv[NZCV_N];
  assign w_z = i_nzcv[NZCV_Z];
  assign w_c = i_nzcv[NZCV_C];
  assign w_v = i_nzcv[NZCV_V];

  always_comb begin
    o_pass = 1'b0;
    unique case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = !w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = !w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = !w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = !w_v;
      COND_HI: o_pass = w_c && !w_z;
      COND_LS: o_pass = !w_c || w_z;
      COND_GE: o_pass = (w_n == w_v);
      COND_LT: o_pass = (w_n != w_v);
      COND_GT: o_pass = !w_z && (w_n == w_v);
      COND_LE: o_pass = w_z || (w_n != w_v);
      // NV is treated as always, like AL
      COND_AL: o_pass = 1'b1;
      COND_NV: o_pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Conditional execute front-end for the shifter/ALU; owns the NZCV register.
// Executed op: rsp_valid 2 cycles after accept, skipped op: 1 cycle; holds response until rsp_ready.
module alu_exec_ctrl
  import alu_exec_pkg::*;
#(
  parameter int         DATA_W   = 32,
  parameter logic [3:0] NZCV_RST = 4'b0000
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_cond,
  input  logic              req_s,
  input  logic [3:0]        req_alu_op,
  input  logic [2:0]        req_shift_op,
  input  logic [7:0]        req_shift_num,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_shift_data,
  input  logic [3:0]        req_rd,

  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_shift_data,
  output logic [3:0]        alu_op,
  output logic [2:0]        alu_shift_op,
  output logic [7:0]        alu_shift_num,
  output logic              alu_s,
  output logic              alu_c_in,
  input  logic [DATA_W-1:0] alu_f,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_rd,
  output logic              rsp_we,
  output logic [3:0]        nzcv
);

  state_t r_state;
  state_t w_state_nxt;

  logic [3:0]        r_nzcv;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_shift_data;
  logic [3:0]        r_alu_op;
  logic [2:0]        r_alu_shift_op;
  logic [7:0]        r_alu_shift_num;
  logic              r_alu_s;
  logic [DATA_W-1:0] r_rsp_result;
  logic [3:0]        r_rsp_rd;
  logic              r_rsp_we;

  logic w_pass;
  logic w_req_ready;
  logic w_rsp_valid;
  logic w_accept;
  logic w_exec;

  cond_check u_cond_check (
    .i_cond (req_cond),
    .i_nzcv (r_nzcv),
    .o_pass (w_pass)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (req_valid) begin
          w_state_nxt = w_pass ? ST_EXEC : ST_RESP;
        end
      end
      ST_EXEC: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        w_rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_accept = w_req_ready && req_valid;
  assign w_exec   = (r_state == ST_EXEC);

  // Flags change only on the EXEC edge, so the next request always sees them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nzcv           <= NZCV_RST;
      r_alu_a          <= '0;
      r_alu_shift_data <= '0;
      r_alu_op         <= '0;
      r_alu_shift_op   <= '0;
      r_alu_shift_num  <= '0;
      r_alu_s          <= 1'b0;
      r_rsp_result     <= '0;
      r_rsp_rd         <= '0;
      r_rsp_we         <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rsp_rd <= req_rd;
        if (w_pass) begin
          r_alu_a          <= req_a;
          r_alu_shift_data <= req_shift_data;
          r_alu_op         <= req_alu_op;
          r_alu_shift_op   <= req_shift_op;
          r_alu_shift_num  <= req_shift_num;
          r_alu_s          <= req_s;
        end else begin
          r_rsp_result <= '0;
          r_rsp_we     <= 1'b0;
        end
      end
      if (w_exec) begin
        r_rsp_result <= alu_f;
        r_rsp_we     <= 1'b1;
        if (r_alu_s) begin
          r_nzcv <= {alu_n, alu_z, alu_c, alu_v};
        end
      end
    end
  end

  assign req_ready      = w_req_ready;
  assign rsp_valid      = w_rsp_valid;
  assign rsp_result     = r_rsp_result;
  assign rsp_rd         = r_rsp_rd;
  assign rsp_we         = r_rsp_we;
  assign nzcv           = r_nzcv;
  assign alu_a          = r_alu_a;
  assign alu_shift_data = r_alu_shift_data;
  assign alu_op         = r_alu_op;
  assign alu_shift_op   = r_alu_shift_op;
  assign alu_shift_num  = r_alu_shift_num;
  assign alu_s          = r_alu_s;
  assign alu_c_in       = r_nzcv[NZCV_C];

endmodule
